// File: rtl/predictor_pkg.sv
// Shared helpers for the gshare branch predictor: saturating arithmetic,
// the table index hash, and default table geometry.
package predictor_pkg;

  localparam int unsigned DEF_INDEX_BITS = 4;
  localparam int unsigned DEF_CTR_BITS   = 2;
  localparam int unsigned CTR_MAX        = (1 << DEF_CTR_BITS) - 1;
  localparam int unsigned TABLE_DEPTH    = 1 << DEF_INDEX_BITS;

  // All-ones value of a w-bit field (w up to 32).
  function automatic logic [31:0] sat_max(input int unsigned w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return (v >= sat_max(w)) ? sat_max(w) : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int unsigned w);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  // Word-aligned PC bits, optionally folded with the global history.
  function automatic logic [31:0] gshare_index(input logic [31:0] pc,
                                               input logic [31:0] ghr,
                                               input int unsigned index_bits,
                                               input int unsigned hist_bits,
                                               input bit          use_gshare);
    logic [31:0] idx;
    idx = (pc >> 2) & sat_max(index_bits);
    if (use_gshare && hist_bits > 0) idx = idx ^ (ghr & sat_max(hist_bits));
    return idx;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of saturating direction counters with one registered read port
// (direction bit only) and one saturating update port.
module sat_counter_table
  import predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_pred,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_taken
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_TOP = '1;

  logic [CTR_BITS-1:0] ctr_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_d [DEPTH];
  logic                rd_pred_q;
  logic                rd_pred_d;

  // Read samples the pre-update counter, so a same-cycle write is not visible.
  always_comb begin
    ctr_d     = ctr_q;
    rd_pred_d = rd_pred_q;
    if (rd_en) rd_pred_d = ctr_q[rd_index][CTR_BITS-1];
    if (wr_en) begin
      if (wr_taken) ctr_d[wr_index] = CTR_BITS'(sat_inc(32'(ctr_q[wr_index]), CTR_BITS));
      else          ctr_d[wr_index] = CTR_BITS'(sat_dec(32'(ctr_q[wr_index]), CTR_BITS));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_TOP;
      rd_pred_q <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      rd_pred_q <= rd_pred_d;
    end
  end

  assign rd_pred = rd_pred_q;

endmodule

// File: rtl/gshare_predictor.sv
// Gshare dynamic branch predictor: history register, index hash, output
// registers and saturating resolve statistics around the counter table.
module gshare_predictor
  import predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HIST_BITS  = 4,
  parameter bit          USE_GSHARE = 1'b1,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request,
  input  logic [PC_WIDTH-1:0]   req_pc,
  output logic                  prediction,
  output logic                  pred_valid,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  result,
  input  logic [INDEX_BITS-1:0] res_index,
  input  logic                  taken,
  input  logic                  res_pred,
  output logic [STAT_BITS-1:0]  branch_count,
  output logic [STAT_BITS-1:0]  miss_count
);

  localparam int unsigned GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [GHR_W-1:0]      ghr_q, ghr_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
  logic                  pred_valid_q, pred_valid_d;
  logic [STAT_BITS-1:0]  branch_count_q, branch_count_d;
  logic [STAT_BITS-1:0]  miss_count_q, miss_count_d;
  logic [INDEX_BITS-1:0] req_index_c;

  assign req_index_c = INDEX_BITS'(gshare_index(32'(req_pc), 32'(ghr_q),
                                                INDEX_BITS, HIST_BITS, USE_GSHARE));

  sat_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (request),
    .rd_index (req_index_c),
    .rd_pred  (prediction),
    .wr_en    (result),
    .wr_index (res_index),
    .wr_taken (taken)
  );

  // History is only advanced by resolved outcomes (non-speculative).
  always_comb begin
    ghr_d          = ghr_q;
    pred_index_d   = pred_index_q;
    pred_valid_d   = request;
    branch_count_d = branch_count_q;
    miss_count_d   = miss_count_q;
    if (request) pred_index_d = req_index_c;
    if (result) begin
      ghr_d          = (HIST_BITS > 0) ? GHR_W'({ghr_q, taken}) : '0;
      branch_count_d = STAT_BITS'(sat_inc(32'(branch_count_q), STAT_BITS));
      if (res_pred != taken)
        miss_count_d = STAT_BITS'(sat_inc(32'(miss_count_q), STAT_BITS));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q          <= '0;
      pred_index_q   <= '0;
      pred_valid_q   <= 1'b0;
      branch_count_q <= '0;
      miss_count_q   <= '0;
    end else begin
      ghr_q          <= ghr_d;
      pred_index_q   <= pred_index_d;
      pred_valid_q   <= pred_valid_d;
      branch_count_q <= branch_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign pred_index   = pred_index_q;
  assign pred_valid   = pred_valid_q;
  assign branch_count = branch_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised dynamic branch predictor: a table of 2^INDEX_BITS saturating counters, indexed by PC bits optionally XORed with a global history register (gshare mode). Sits beside the fetch stage. Fetch issues a prediction request with a PC; execute later returns the resolved outcome with the table index that fetch was given. Supersedes the single 2-bit counter predictor; adds per-branch state, history correlation, configurable counter width, and mispredict statistics.

## Interface
- INDEX_BITS, 4: table has 2^INDEX_BITS entries
- CTR_BITS, 2: saturating counter width (>=1)
- HIST_BITS, 4: global history length (0..INDEX_BITS; 0 means no history)
- USE_GSHARE, 1: 1 means index = PC bits XOR history; 0 means index = PC bits only
- PC_WIDTH, 32: PC width (>= INDEX_BITS+2)
- STAT_BITS, 16: statistics counter width

- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high
- request  in  1  prediction request this cycle
- req_pc  in  PC_WIDTH  PC of branch to predict
- prediction  out  1  predicted direction (1 = taken)
- pred_valid  out  1  one-cycle pulse: prediction/pred_index valid
- pred_index  out  INDEX_BITS  table index used; caller returns it on resolve
- result  in  1  resolved outcome presented this cycle
- res_index  in  INDEX_BITS  index previously returned on pred_index
- taken  in  1  actual direction
- res_pred  in  1  direction that was predicted for this branch
- branch_count  out  STAT_BITS  resolved branches, saturating
- miss_count  out  STAT_BITS  mispredicts, saturating

## Operation
- Index on request: pcidx = req_pc[INDEX_BITS+1:2]. If USE_GSHARE=1 and HIST_BITS>0: index = pcidx XOR {zeros, ghr}; otherwise index = pcidx.
- prediction = MSB of table[index]; pred_index = index.
- Resolve (result=1): table[res_index] increments if taken=1, decrements if taken=0; saturates at 2^CTR_BITS-1 and 0 (no wrap).
- ghr (HIST_BITS) shifts left with taken into bit 0 on each result. Update is non-speculative.
- branch_count increments on each result. miss_count increments when result=1 and res_pred != taken. Both hold at all-ones.
- Reset values: every counter = 2^CTR_BITS-1 (strongly taken), ghr=0, prediction=0, pred_valid=0, pred_index=0, both stats=0.
- Reset asserted mid-operation clears all of the above immediately. An in-flight result in the same cycle is discarded.

## Timing
- Request to prediction latency is 1 cycle. request sampled at edge N; prediction, pred_index and pred_valid are valid after edge N.
- pred_valid is high exactly one cycle per request. It stays high across back-to-back requests.
- prediction and pred_index hold their last values until the next request.
- Result takes effect at the sampling edge. Table, ghr and stats show the new values from the next cycle.
- request and result in the same cycle: the prediction reads the pre-update counter and the pre-update ghr, even when index == res_index. The update then commits.
- A request one cycle after a result sees the updated counter and history.
- Only one result per cycle is accepted. No backpressure: request and result are always accepted.

## Structure
- Package predictor_pkg holds:
  - sat_inc/sat_dec functions, parameterised by width
  - a gshare index function
  - localparams CTR_MAX and TABLE_DEPTH
- Sub-module sat_counter_table: 2^INDEX_BITS x CTR_BITS flop array with async reset to CTR_MAX, one registered read port, and one saturating update port.
- The top level holds ghr, the index logic, the output registers and the statistics counters.

## Test plan
- Reset, then request pc=0x40: after 1 cycle pred_valid=1, prediction=1, pred_index=0x0. Both stats read 0.
- Four results with res_index=3, taken=0, then request mapping to index 3 with USE_GSHARE=0: counter 3->0 saturates, prediction=0. A fifth not-taken result leaves the counter at 0.
- gshare: results with taken=1,0,1,1 give ghr=0b1011. Then request pc=0x08 (pcidx=2): pred_index=0x9.
- Same-cycle request and result on index 5 (counter=2, taken=0): prediction=1 (old value). A following request on index 5 gives prediction=0.
- Results with res_pred != taken, 3 of 10: branch_count=10, miss_count=3. With STAT_BITS=4, 20 results leave branch_count saturated at 15.
- Assert reset mid-stream after training index 2 to 0: table returns to all-ones, ghr=0, outputs 0, and the next prediction on index 2 is 1.
